// File: rtl/eda_out_stream_pkg.sv
// Shared types and sizing helpers for the output-RAM mask streamer.
// Optional region counter is enabled with EDA_OUT_STREAM_CNT_EN.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif

package eda_out_stream_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic int unsigned calc_num_bits(input int unsigned m, input int unsigned n);
    return m * n;
  endfunction

  function automatic int unsigned calc_num_beats(input int unsigned bits, input int unsigned w);
    return (bits + w - 1) / w;
  endfunction

  // A single-beat transfer still needs a one-bit beat counter.
  function automatic int unsigned calc_beat_w(input int unsigned beats);
    int unsigned w;
    w = $clog2(beats);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/eda_popcount.sv
// Combinational ones-count of a WIDTH-bit vector.
module eda_popcount #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_c
);

  always_comb begin
    count_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      count_c = count_c + CNT_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/eda_output_streamer.sv
// Snapshots the regional-maximum mask on start and streams it row-major as
// OUT_WIDTH-bit beats over valid/ready. EDA_OUT_STREAM_CNT_EN adds region_count.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif

module eda_output_streamer
  import eda_out_stream_pkg::*;
#(
  parameter  int unsigned M         = `CFG_M,
  parameter  int unsigned N         = `CFG_N,
  parameter  int unsigned OUT_WIDTH = 8,
  localparam int unsigned NUM_BITS  = calc_num_bits(M, N),
  localparam int unsigned NUM_BEATS = calc_num_beats(NUM_BITS, OUT_WIDTH),
  localparam int unsigned BEAT_W    = calc_beat_w(NUM_BEATS)
`ifdef EDA_OUT_STREAM_CNT_EN
  ,
  localparam int unsigned CNT_W     = calc_cnt_w(NUM_BITS)
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      start,
  input  logic [M-1:0][N-1:0]       matrix_in,
  output logic                      busy,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUT_WIDTH-1:0]      m_data,
  output logic                      m_last,
  output logic [BEAT_W-1:0]         m_index,
`ifdef EDA_OUT_STREAM_CNT_EN
  output logic [CNT_W-1:0]          region_count,
`endif
  output logic                      done
);

  localparam int unsigned PAD_W = NUM_BEATS * OUT_WIDTH;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  state_e                 state_q, state_d;
  logic [NUM_BITS-1:0]    shadow_q, shadow_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [OUT_WIDTH-1:0]   data_q, data_d;
  logic                   last_q, last_d;
  logic [BEAT_W-1:0]      index_q, index_d;
  logic                   done_q, done_d;
  logic [PAD_W-1:0]       pad_c;
  logic                   start_acc_c;
  logic                   handshake_c;

  // Control: clear wins over start and handshake; start only honoured in IDLE.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    beat_d      = beat_q;
    done_d      = 1'b0;
    start_acc_c = 1'b0;
    handshake_c = 1'b0;
    if (clear) begin
      state_d = IDLE;
      beat_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            start_acc_c = 1'b1;
            shadow_d    = matrix_in;
            beat_d      = '0;
            state_d     = STREAM;
          end
        end
        STREAM: begin
          if (valid_q && m_ready) begin
            handshake_c = 1'b1;
            if (beat_q == LAST_BEAT) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              beat_d = beat_q + BEAT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered beat view; stable across a stall because beat/shadow are held.
  always_comb begin
    pad_c   = PAD_W'(shadow_d);
    valid_d = (state_d == STREAM);
    busy_d  = valid_d;
    last_d  = valid_d && (beat_d == LAST_BEAT);
    index_d = valid_d ? beat_d : '0;
    data_d  = valid_d ? OUT_WIDTH'(pad_c >> (32'(beat_d) * OUT_WIDTH)) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      index_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
      last_q   <= last_d;
      index_q  <= index_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_last  = last_q;
  assign m_index = index_q;
  assign done    = done_q;

`ifdef EDA_OUT_STREAM_CNT_EN
  localparam int unsigned POP_W = $clog2(OUT_WIDTH + 1);

  logic [POP_W-1:0] beat_pop_c;
  logic [CNT_W-1:0] count_q, count_d;

  eda_popcount #(
    .WIDTH (OUT_WIDTH),
    .CNT_W (POP_W)
  ) u_popcount (
    .data_i  (data_q),
    .count_c (beat_pop_c)
  );

  // Accumulates set mask bits of each accepted beat.
  always_comb begin
    count_d = count_q;
    if (clear || start_acc_c) begin
      count_d = '0;
    end else if (handshake_c) begin
      count_d = count_q + CNT_W'(beat_pop_c);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign region_count = count_q;
`else
  logic unused_c;
  assign unused_c = start_acc_c ^ handshake_c;
`endif

endmodule
